// File: rtl/write_ddr_pack.sv
// write_ddr_pack: packs IN_WIDTH-bit words into OUT_WIDTH-bit DDR write beats.
// Words fill lanes 0..7 in order. A beat closes either on the eighth word or
// on s_last, whichever comes first. Unwritten lanes are zero, and their byte
// enables are clear. A single output register provides skid-free
// back-to-back beats: s_rdy depends only on m_rdy and that register's state.
module write_ddr_pack #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_vld,
   output logic                   s_rdy,
   input  logic [IN_WIDTH-1:0]    s_data,
   input  logic                   s_last,
   output logic                   m_vld,
   input  logic                   m_rdy,
   output logic [OUT_WIDTH-1:0]   m_data,
   output logic [OUT_WIDTH/8-1:0] m_be,
   output logic                   m_last,
   output logic [15:0]            beat_cnt
);

   localparam int LANES = OUT_WIDTH / IN_WIDTH;
   localparam int LW    = $clog2(LANES);
   localparam int BPW   = IN_WIDTH / 8;
   localparam int BEW   = OUT_WIDTH / 8;

   logic [LW-1:0]        lane_q,   lane_d;
   logic [OUT_WIDTH-1:0] pack_q,   pack_d;
   logic [BEW-1:0]       pbe_q,    pbe_d;
   logic                 m_vld_q,  m_vld_d;
   logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
   logic [BEW-1:0]       m_be_q,   m_be_d;
   logic                 m_last_q, m_last_d;
   logic [15:0]          cnt_q,    cnt_d;

   logic                 accept_s;
   logic                 close_s;
   logic                 xfer_s;
   logic [OUT_WIDTH-1:0] pack_merge_s;
   logic [BEW-1:0]       be_merge_s;

   // The output register frees up whenever it is empty or is being drained this cycle.
   assign s_rdy    = ~m_vld_q | m_rdy;
   assign m_vld    = m_vld_q;
   assign m_data   = m_data_q;
   assign m_be     = m_be_q;
   assign m_last   = m_last_q;
   assign beat_cnt = cnt_q;

   // Next-state logic: lane merge, beat close, output register load/drain, beat counter.
   always_comb begin
      accept_s     = s_vld & s_rdy;
      close_s      = accept_s & (s_last | (lane_q == LW'(LANES - 1)));
      xfer_s       = m_vld_q & m_rdy;

      pack_merge_s = pack_q;
      be_merge_s   = pbe_q;
      pack_merge_s[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = s_data;
      be_merge_s[int'(lane_q) * BPW +: BPW]             = {BPW{1'b1}};

      lane_d   = lane_q;
      pack_d   = pack_q;
      pbe_d    = pbe_q;
      m_vld_d  = m_vld_q;
      m_data_d = m_data_q;
      m_be_d   = m_be_q;
      m_last_d = m_last_q;

      if (close_s) begin
         // The closing word travels straight into the output register with the rest of the pack.
         lane_d   = {LW{1'b0}};
         pack_d   = {OUT_WIDTH{1'b0}};
         pbe_d    = {BEW{1'b0}};
         m_vld_d  = 1'b1;
         m_data_d = pack_merge_s;
         m_be_d   = be_merge_s;
         m_last_d = s_last;
      end else if (accept_s) begin
         lane_d = lane_q + LW'(1);
         pack_d = pack_merge_s;
         pbe_d  = be_merge_s;
         if (xfer_s) begin
            m_vld_d = 1'b0;
         end else begin
            m_vld_d = m_vld_q;
         end
      end else if (xfer_s) begin
         m_vld_d = 1'b0;
      end else begin
         m_vld_d = m_vld_q;
      end

      if (xfer_s) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset discards any partial pack and any unsent beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q   <= {LW{1'b0}};
         pack_q   <= {OUT_WIDTH{1'b0}};
         pbe_q    <= {BEW{1'b0}};
         m_vld_q  <= 1'b0;
         m_data_q <= {OUT_WIDTH{1'b0}};
         m_be_q   <= {BEW{1'b0}};
         m_last_q <= 1'b0;
         cnt_q    <= 16'd0;
      end else begin
         lane_q   <= lane_d;
         pack_q   <= pack_d;
         pbe_q    <= pbe_d;
         m_vld_q  <= m_vld_d;
         m_data_q <= m_data_d;
         m_be_q   <= m_be_d;
         m_last_q <= m_last_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_write_ddr_pack.sv
// tb_write_ddr_pack: directed self-checking bench for write_ddr_pack.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_write_ddr_pack;

   logic         clk;
   logic         rst_n;
   logic         s_vld;
   logic         s_rdy;
   logic [31:0]  s_data;
   logic         s_last;
   logic         m_vld;
   logic         m_rdy;
   logic [255:0] m_data;
   logic [31:0]  m_be;
   logic         m_last;
   logic [15:0]  beat_cnt;

   int total = 0;
   int bad   = 0;
   int stalls = 0;
   logic mon_en = 1'b0;

   logic [255:0] got_data[$];
   logic [31:0]  got_be[$];
   logic         got_last[$];

   write_ddr_pack #(.IN_WIDTH(32), .OUT_WIDTH(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data), .s_last(s_last),
      .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_be(m_be),
      .m_last(m_last), .beat_cnt(beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every beat handed downstream; inputs are stable from here to the next rising edge.
   always @(negedge clk) begin
      if (mon_en && m_vld && m_rdy && rst_n) begin
         got_data.push_back(m_data);
         got_be.push_back(m_be);
         got_last.push_back(m_last);
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word, wait (bounded) for s_rdy, and return 1 unit after the accepting edge.
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      s_vld  = 1'b1;
      s_data = d;
      s_last = l;
      @(negedge clk);
      while (!s_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      stalls += n;
      if (n >= 50) begin
         chk("send_timeout", 256'(n), 256'(0));
      end
      tick();
      s_vld  = 1'b0;
      s_last = 1'b0;
   endtask

   initial begin
      logic [255:0] e;
      logic [255:0] e1;
      logic [255:0] e2;
      int n;

      rst_n = 1'b0; s_vld = 1'b0; s_data = 32'd0; s_last = 1'b0; m_rdy = 1'b1;
      #12;
      // reset state
      chk("rst_m_vld", 256'(m_vld), 256'(1'b0));
      chk("rst_s_rdy", 256'(s_rdy), 256'(1'b1));
      chk("rst_m_data", m_data, 256'd0);
      chk("rst_beat_cnt", 256'(beat_cnt), 256'(16'd0));
      tick();
      rst_n = 1'b1;
      tick();

      // eight words 1..8 with an idle gap mid-pack
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'(i + 1);
      for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
      tick(); tick(); tick();
      chk("gap_m_vld", 256'(m_vld), 256'(1'b0));
      for (int i = 5; i <= 7; i++) send(32'(i), 1'b0);
      chk("pre8_m_vld", 256'(m_vld), 256'(1'b0));
      send(32'd8, 1'b0);
      chk("b1_m_vld", 256'(m_vld), 256'(1'b1));
      chk("b1_m_data", m_data, e);
      chk("b1_m_be", 256'(m_be), 256'(32'hFFFF_FFFF));
      chk("b1_m_last", 256'(m_last), 256'(1'b0));
      tick();
      chk("b1_drained", 256'(m_vld), 256'(1'b0));
      chk("b1_beat_cnt", 256'(beat_cnt), 256'(16'd1));

      // three words closed by s_last
      send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b1);
      chk("p3_m_data", m_data, {160'd0, 96'h0000000C_0000000B_0000000A});
      chk("p3_m_be", 256'(m_be), 256'(32'h0000_0FFF));
      chk("p3_m_last", 256'(m_last), 256'(1'b1));
      tick();
      chk("p3_beat_cnt", 256'(beat_cnt), 256'(16'd2));

      // s_last on an empty pack
      send(32'hDEAD_BEEF, 1'b1);
      chk("p1_m_data", m_data, {224'd0, 32'hDEAD_BEEF});
      chk("p1_m_be", 256'(m_be), 256'(32'h0000_000F));
      chk("p1_m_last", 256'(m_last), 256'(1'b1));
      tick();

      // s_last on lane 7 closes exactly one full beat
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'h300 + 32'(i);
      for (int i = 0; i < 7; i++) send(32'h300 + 32'(i), 1'b0);
      send(32'h307, 1'b1);
      chk("l7_m_data", m_data, e);
      chk("l7_m_be", 256'(m_be), 256'(32'hFFFF_FFFF));
      chk("l7_m_last", 256'(m_last), 256'(1'b1));
      tick();
      chk("l7_single_beat", 256'(m_vld), 256'(1'b0));
      chk("l7_beat_cnt", 256'(beat_cnt), 256'(16'd4));

      // 16 back-to-back words at full rate
      mon_en = 1'b1; stalls = 0;
      got_data.delete(); got_be.delete(); got_last.delete();
      for (int i = 0; i < 16; i++) send(32'h400 + 32'(i), 1'b0);
      tick(); tick();
      for (int i = 0; i < 8; i++) e1[i*32 +: 32] = 32'h400 + 32'(i);
      for (int i = 0; i < 8; i++) e2[i*32 +: 32] = 32'h408 + 32'(i);
      chk("ff_no_stall", 256'(stalls), 256'(0));
      chk("ff_beats", 256'(got_data.size()), 256'(2));
      if (got_data.size() == 2) begin
         chk("ff_beat0", got_data[0], e1);
         chk("ff_beat1", got_data[1], e2);
      end
      chk("ff_beat_cnt", 256'(beat_cnt), 256'(16'd6));

      // backpressure across 24 words
      stalls = 0;
      got_data.delete(); got_be.delete(); got_last.delete();
      for (int i = 0; i < 8; i++) e1[i*32 +: 32] = 32'h500 + 32'(i);
      m_rdy = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) send(32'h500 + 32'(i), 1'b0);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!m_vld && n < 50) begin
               @(negedge clk);
               n++;
            end
            chk("bp_wait_vld", 256'(n < 50), 256'(1'b1));
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("bp_s_rdy_low", 256'(s_rdy), 256'(1'b0));
               chk("bp_hold_data", m_data, e1);
            end
            tick();
            m_rdy = 1'b1;
         end
      join
      tick(); tick();
      chk("bp_stalled", 256'(stalls > 0), 256'(1'b1));
      chk("bp_beats", 256'(got_data.size()), 256'(3));
      if (got_data.size() == 3) begin
         for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'h500 + 32'(b * 8 + i);
            chk("bp_beat_data", got_data[b], e);
            chk("bp_beat_be", 256'(got_be[b]), 256'(32'hFFFF_FFFF));
         end
      end
      chk("bp_beat_cnt", 256'(beat_cnt), 256'(16'd9));
      mon_en = 1'b0;

      // reset mid-beat
      for (int i = 0; i < 5; i++) send(32'h600 + 32'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mr_m_vld", 256'(m_vld), 256'(1'b0));
      chk("mr_m_data", m_data, 256'd0);
      chk("mr_m_be", 256'(m_be), 256'(32'd0));
      chk("mr_m_last", 256'(m_last), 256'(1'b0));
      chk("mr_beat_cnt", 256'(beat_cnt), 256'(16'd0));
      chk("mr_s_rdy", 256'(s_rdy), 256'(1'b1));
      tick(); tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'h10 + 32'(i);
      for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), 1'b0);
      chk("ar_m_vld", 256'(m_vld), 256'(1'b1));
      chk("ar_lane0", 256'(m_data[31:0]), 256'(32'h10));
      chk("ar_m_data", m_data, e);
      chk("ar_m_be", 256'(m_be), 256'(32'hFFFF_FFFF));
      tick();
      chk("ar_beat_cnt", 256'(beat_cnt), 256'(16'd1));

      // beat counter wrap: single-word beats at one per cycle
      s_vld = 1'b1; s_last = 1'b1; s_data = 32'h77;
      repeat (65534) tick();
      s_vld = 1'b0; s_last = 1'b0;
      tick();
      chk("wrap_ffff", 256'(beat_cnt), 256'(16'hFFFF));
      send(32'h78, 1'b1);
      tick();
      chk("wrap_zero", 256'(beat_cnt), 256'(16'h0000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/write_ddr_pack.md
WRITE_DDR_PACK -- requirements
Module: write_ddr_pack

Interface
REQ-001 Parameter: IN_WIDTH, 32, width of one input word.
REQ-002 Parameter: OUT_WIDTH, 256, width of one packed DDR write beat; SHALL equal 8*IN_WIDTH.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: s_vld  input  1  input word valid.
REQ-006 Port: s_rdy  output  1  input word accepted when s_vld&s_rdy.
REQ-007 Port: s_data  input  IN_WIDTH  input word.
REQ-008 Port: s_last  input  1  qualified by s_vld&s_rdy; closes the current beat, zero-padding the remaining lanes.
REQ-009 Port: m_vld  output  1  packed beat valid.
REQ-010 Port: m_rdy  input  1  downstream (DDR write FIFO) accepts the beat when m_vld&m_rdy.
REQ-011 Port: m_data  output  OUT_WIDTH  packed beat.
REQ-012 Port: m_be  output  OUT_WIDTH/8  byte enables, 1 = byte carries real data.
REQ-013 Port: m_last  output  1  beat was closed by s_last.
REQ-014 Port: beat_cnt  output  16  count of beats transferred on m side; wraps 0xFFFF->0.

Function
REQ-015 Lane index lane_cnt (3 bits) SHALL select the input word's position: word accepted at lane k lands in m_data[32k+31:32k]; the first word after reset or after a closed beat goes to lane 0 (bits [31:0]).
REQ-016 Each accepted word SHALL write its lane of an internal pack register and set the 4 matching bits of an internal byte-enable register.
REQ-017 A beat SHALL close when a word is accepted at lane 7 or is accepted with s_last=1; on close, pack data, byte enables and s_last move to the output register, the pack register and its byte enables clear, and lane_cnt returns to 0.
REQ-018 A word accepted at lane 7 with s_last=1 SHALL close exactly one beat with m_be all ones and m_last=1.
REQ-019 Lanes not written before an s_last close SHALL be zero in m_data and 0 in m_be.
REQ-020 s_rdy SHALL equal (~m_vld | m_rdy), combinational from m_rdy and the output register state.
REQ-021 Latency: a beat closed in cycle N SHALL present m_vld=1 in cycle N+1.
REQ-022 m_vld SHALL set on close and clear on m_vld&m_rdy unless a new close occurs in the same cycle, in which case m_vld stays 1 and the output register reloads (back-to-back beats, no bubble).
REQ-023 m_data, m_be and m_last SHALL hold stable while m_vld=1 and m_rdy=0.
REQ-024 With m_rdy held high and s_vld held high, throughput SHALL be 8 input words per output beat with no stalls.
REQ-025 beat_cnt SHALL increment by 1 on every m_vld&m_rdy cycle.
REQ-026 s_last on an empty pack register (lane_cnt=0) SHALL still close a beat containing only that word (m_be = 0x0000000F).
REQ-027 s_vld=0 SHALL leave lane_cnt, pack register and output register unchanged; a partially filled pack register SHALL wait indefinitely for further words.

Reset
REQ-028 On rst_n=0, asynchronously: m_vld=0, m_last=0, m_data=0, m_be=0, beat_cnt=0, lane_cnt=0, pack register and byte enables cleared; s_rdy therefore reads 1.
REQ-029 Reset asserted mid-beat SHALL discard the partial pack and any unsent output beat; the first word after release goes to lane 0.

Verification
REQ-030 Words 0x00000001..0x00000008, m_rdy=1 -> one beat, m_data = 0x00000008_..._00000001 (lane 0 = 0x1), m_be=0xFFFFFFFF, m_last=0, m_vld one cycle after 8th accept, beat_cnt=1.
REQ-031 Three words 0xA,0xB,0xC with s_last on 0xC -> m_data[95:0]=0x0000000C_0000000B_0000000A, upper lanes 0, m_be=0x00000FFF, m_last=1.
REQ-032 16 consecutive words, m_rdy=1 -> two beats on consecutive m_vld cycles, s_rdy never low, beat_cnt=2.
REQ-033 m_rdy=0 after first beat closes, continue feeding -> s_rdy drops, first beat m_data stable; raise m_rdy -> first beat transfers, no word lost or duplicated across 24 words.
REQ-034 Reset pulse after 5 words accepted -> all outputs 0; then 8 words 0x10..0x17 -> lane 0 = 0x10, m_be all ones.
REQ-035 beat_cnt preloaded by sending 65535 beats then one more -> beat_cnt wraps to 0.
